// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port and unified-memory port
// of mem_arbiter.
//   if_*   : instruction-fetch request/response
//   dm_*   : load/store request/response
//   mem_*  : single-ported memory access (mem_rdata returns from memory)
//   grant_dm : owner of the current or last access (1 = data port)
// Modports: slave = the arbiter; master = everything around it (core + memory).
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              grant_dm;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_valid, if_rdata, dm_ready, dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, grant_dm
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_valid, if_rdata, dm_ready, dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, grant_dm
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and
// load/store. One access at a time, fixed MEM_LATENCY cycles per access, a
// one-cycle valid pulse back to the owning port. Data has priority; fetch is
// forced through after MAX_DM_BURST consecutive data grants while it waits.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mem_arbiter_if.slave (fetch port, data port, memory port)
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned MAX_DM_BURST = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned    CNT_W     = 4;
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DM_BURST);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  lat_cnt_q,   lat_cnt_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              grant_dm_q,  grant_dm_d;
    logic              if_valid_q,  if_valid_d;
    logic              dm_valid_q,  dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_ready_c;
    logic              dm_ready_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            burst_cnt_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_dm_q  <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_dm_q  <= grant_dm_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Arbitration, access sequencing and response capture
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_dm_d  = grant_dm_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_c  = 1'b0;
        dm_ready_c  = 1'b0;

        case (state_q)
            IDLE: begin
                // Fetch wins when data is quiet or data has used up its burst.
                if (bus.if_req && (!bus.dm_req || (burst_cnt_q == BURST_MAX))) begin
                    if_ready_c  = 1'b1;
                    state_d     = ACCESS;
                    lat_cnt_d   = LAT_LOAD;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    grant_dm_d  = 1'b0;
                    burst_cnt_d = '0;
                end else if (bus.dm_req) begin
                    dm_ready_c  = 1'b1;
                    state_d     = ACCESS;
                    lat_cnt_d   = LAT_LOAD;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    grant_dm_d  = 1'b1;
                    // Only count data grants that actually made fetch wait.
                    if (!bus.if_req) begin
                        burst_cnt_d = '0;
                    end else if (burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end
            end
            ACCESS: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end else begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (grant_dm_q) begin
                        dm_valid_d = 1'b1;
                        // Stores complete without touching the load data.
                        if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.if_ready  = if_ready_c;
    assign bus.dm_ready  = dm_ready_c;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter at three access latencies.
// Each instance gets a small word-addressed memory model behind mem_*.
module tb_mem_arbiter;

    localparam logic [31:0] FETCH_WORD = 32'h0050_0093;
    localparam logic [31:0] B2B_W0     = 32'h1111_0001;
    localparam logic [31:0] B2B_W1     = 32'h2222_0002;
    localparam logic [31:0] B2B_W2     = 32'h3333_0003;
    localparam logic [31:0] B2B_W3     = 32'h4444_0004;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_arbiter #(.MEM_LATENCY(1), .MAX_DM_BURST(2), .ADDR_W(32), .DATA_W(32))
        u_l1 (.clk(clk), .reset(reset), .bus(b1.slave));
    mem_arbiter #(.MEM_LATENCY(2), .MAX_DM_BURST(2), .ADDR_W(32), .DATA_W(32))
        u_l2 (.clk(clk), .reset(reset), .bus(b2.slave));
    mem_arbiter #(.MEM_LATENCY(3), .MAX_DM_BURST(2), .ADDR_W(32), .DATA_W(32))
        u_l3 (.clk(clk), .reset(reset), .bus(b3.slave));

    // Memory models: b1/b3 read-only preloaded, b2 read/write.
    logic [31:0] mem1 [0:255];
    logic [31:0] mem2 [0:255];
    logic [31:0] mem3 [0:255];

    assign b1.mem_rdata = mem1[b1.mem_addr[9:2]];
    assign b2.mem_rdata = mem2[b2.mem_addr[9:2]];
    assign b3.mem_rdata = mem3[b3.mem_addr[9:2]];

    always @(posedge clk) begin
        if (b2.mem_en && b2.mem_we) mem2[b2.mem_addr[9:2]] <= b2.mem_wdata;
    end

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.if_valid, b1.dm_valid,
             b1.if_rdata, b1.dm_rdata, b1.grant_dm} !== '0) begin
            n_err++;
            $display("FAIL reset_values_l1: got nonzero outputs en=%b we=%b addr=%h", b1.mem_en, b1.mem_we, b1.mem_addr);
        end
        @(negedge clk);
        reset = 1'b1;

        // Start a store on the latency-3 instance, then reset in its ACCESS phase.
        @(negedge clk);
        b3.dm_req = 1'b1; b3.dm_we = 1'b1; b3.dm_addr = 32'h40; b3.dm_wdata = 32'h1234_5678;
        #1;
        n_cmp++;
        if (b3.dm_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_store_accept: dm_ready got %b expected 1", b3.dm_ready);
        end
        @(negedge clk);
        b3.dm_req = 1'b0; b3.dm_we = 1'b0;
        #1;
        n_cmp++;
        if ({b3.mem_en, b3.mem_we} !== 2'b11) begin
            n_err++; $display("FAIL reset_in_access: en,we got %b expected 11", {b3.mem_en, b3.mem_we});
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({b3.mem_en, b3.mem_we} !== 2'b00) begin
            n_err++; $display("FAIL reset_async_drop: en,we got %b expected 00", {b3.mem_en, b3.mem_we});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (b3.if_valid !== 1'b0 || b3.dm_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_no_valid: cycle %0d if_valid=%b dm_valid=%b expected 0", i, b3.if_valid, b3.dm_valid);
            end
        end
        n_cmp++;
        if ({b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, b3.if_rdata, b3.dm_rdata,
             b3.grant_dm, b3.if_ready, b3.dm_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_zero: addr=%h wdata=%h grant_dm=%b expected all 0", b3.mem_addr, b3.mem_wdata, b3.grant_dm);
        end
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        b1.if_req = 1'b1; b1.if_addr = 32'h0000_0010;
        #1;
        n_cmp++;
        if (b1.if_ready !== 1'b1) begin
            n_err++; $display("FAIL fetch_ready_T: got %b expected 1", b1.if_ready);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({b1.mem_en, b1.mem_we, b1.if_valid, b1.if_ready} !== 4'b1000 || b1.mem_addr !== 32'h10) begin
            n_err++;
            $display("FAIL fetch_access_T1: en,we,valid,ready got %b expected 1000, addr %h expected 10",
                     {b1.mem_en, b1.mem_we, b1.if_valid, b1.if_ready}, b1.mem_addr);
        end
        b1.if_req = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (b1.if_valid !== 1'b1 || b1.if_rdata !== FETCH_WORD || b1.mem_en !== 1'b0 || b1.grant_dm !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_valid_T2: valid=%b rdata=%h en=%b grant_dm=%b expected 1 %h 0 0",
                     b1.if_valid, b1.if_rdata, b1.mem_en, b1.grant_dm, FETCH_WORD);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (b1.if_valid !== 1'b0 || b1.if_rdata !== FETCH_WORD) begin
            n_err++; $display("FAIL fetch_pulse_end: valid=%b rdata=%h expected 0 %h", b1.if_valid, b1.if_rdata, FETCH_WORD);
        end
    endtask

    task automatic test_store_load();
        bit exp_we [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit exp_v  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        b2.dm_req = 1'b1; b2.dm_we = 1'b1; b2.dm_addr = 32'h100; b2.dm_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (b2.dm_ready !== 1'b1) begin
            n_err++; $display("FAIL store_ready: got %b expected 1", b2.dm_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b2.dm_req = 1'b0; b2.dm_we = 1'b0;
            #1;
            n_cmp++;
            if (b2.mem_we !== exp_we[i] || b2.dm_valid !== exp_v[i]) begin
                n_err++;
                $display("FAIL store_cycle%0d: mem_we=%b dm_valid=%b expected %b %b", i + 1, b2.mem_we, b2.dm_valid, exp_we[i], exp_v[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if (b2.dm_rdata !== 32'h0 || b2.grant_dm !== 1'b1) begin
                    n_err++; $display("FAIL store_rdata_kept: dm_rdata=%h grant_dm=%b expected 0 1", b2.dm_rdata, b2.grant_dm);
                end
            end
        end
        b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 32'h100;
        #1;
        n_cmp++;
        if (b2.dm_ready !== 1'b1) begin
            n_err++; $display("FAIL load_ready: got %b expected 1", b2.dm_ready);
        end
        @(negedge clk);
        b2.dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (b2.dm_valid !== 1'b1 || b2.dm_rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL load_data: dm_valid=%b dm_rdata=%h expected 1 deadbeef", b2.dm_valid, b2.dm_rdata);
        end
    endtask

    task automatic test_contention();
        bit exp_dm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bit got_dm [6];
        int ng = 0;
        @(negedge clk);
        b1.if_req = 1'b1; b1.if_addr = 32'h10;
        b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h14;
        for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            n_cmp++;
            if ((b1.if_ready || b1.dm_ready) && (b1.mem_en || (b1.if_ready && b1.dm_ready))) begin
                n_err++;
                $display("FAIL contention_ready: cycle %0d if_ready=%b dm_ready=%b mem_en=%b expected one ready in IDLE only",
                         cyc, b1.if_ready, b1.dm_ready, b1.mem_en);
            end
            if (b1.if_ready || b1.dm_ready) begin
                got_dm[ng] = b1.dm_ready;
                ng++;
            end
        end
        @(negedge clk);
        b1.if_req = 1'b0; b1.dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ng != 6) begin
            n_err++; $display("FAIL contention_count: got %0d grants expected 6", ng);
        end
        for (int i = 0; i < ng; i++) begin
            n_cmp++;
            if (got_dm[i] !== exp_dm[i]) begin
                n_err++; $display("FAIL contention_order: grant %0d dm=%b expected %b", i, got_dm[i], exp_dm[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4] = '{32'h20, 32'h24, 32'h28, 32'h2C};
        logic [31:0] exp_d [4] = '{B2B_W0, B2B_W1, B2B_W2, B2B_W3};
        int vcyc [4];
        int k = 0;
        int nv = 0;
        bit acc_prev = 1'b0;
        @(negedge clk);
        b3.if_req = 1'b1; b3.if_addr = addrs[0];
        for (int cyc = 0; cyc < 60 && nv < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (acc_prev) begin
                k++;
                if (k < 4) b3.if_addr = addrs[k];
                else       b3.if_req = 1'b0;
            end
            #1;
            if (b3.if_valid) begin
                n_cmp++;
                if (b3.if_rdata !== exp_d[nv] || b3.mem_addr !== addrs[nv]) begin
                    n_err++;
                    $display("FAIL b2b_data%0d: rdata=%h addr=%h expected %h %h", nv, b3.if_rdata, b3.mem_addr, exp_d[nv], addrs[nv]);
                end
                vcyc[nv] = cyc;
                nv++;
            end
            acc_prev = b3.if_ready;
        end
        b3.if_req = 1'b0;
        n_cmp++;
        if (nv != 4) begin
            n_err++; $display("FAIL b2b_timeout: got %0d valids expected 4", nv);
        end
        for (int i = 1; i < nv; i++) begin
            n_cmp++;
            if (vcyc[i] - vcyc[i-1] != 4) begin
                n_err++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 4", i, vcyc[i] - vcyc[i-1]);
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_req_during_access();
        @(negedge clk);
        b3.if_req = 1'b1; b3.if_addr = 32'h20;
        #1;
        n_cmp++;
        if (b3.if_ready !== 1'b1) begin
            n_err++; $display("FAIL rda_fetch_ready: got %b expected 1", b3.if_ready);
        end
        @(negedge clk);
        b3.if_req = 1'b0;
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 32'h24;
            #1;
            n_cmp++;
            if (b3.dm_ready !== 1'b0 || b3.mem_en !== 1'b1) begin
                n_err++; $display("FAIL rda_blocked_T%0d: dm_ready=%b mem_en=%b expected 0 1", i, b3.dm_ready, b3.mem_en);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (b3.if_valid !== 1'b1 || b3.dm_ready !== 1'b1 || b3.if_rdata !== B2B_W0) begin
            n_err++;
            $display("FAIL rda_ready_with_valid: if_valid=%b dm_ready=%b if_rdata=%h expected 1 1 %h",
                     b3.if_valid, b3.dm_ready, b3.if_rdata, B2B_W0);
        end
        @(negedge clk);
        b3.dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (b3.dm_valid !== 1'b1 || b3.dm_rdata !== B2B_W1) begin
            n_err++; $display("FAIL rda_load_done: dm_valid=%b dm_rdata=%h expected 1 %h", b3.dm_valid, b3.dm_rdata, B2B_W1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem1[4]  = FETCH_WORD;
        mem1[5]  = 32'hCAFE_0005;
        mem3[8]  = B2B_W0;
        mem3[9]  = B2B_W1;
        mem3[10] = B2B_W2;
        mem3[11] = B2B_W3;

        b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
        b2.if_req = 1'b0; b2.if_addr = '0; b2.dm_req = 1'b0; b2.dm_we = 1'b0; b2.dm_addr = '0; b2.dm_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.dm_req = 1'b0; b3.dm_we = 1'b0; b3.dm_addr = '0; b3.dm_wdata = '0;
        reset = 1'b0;

        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_req_during_access();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
